// File: rtl/postalu_cc_pkg.sv
// postalu_cc_pkg: shared codes for the execute-stage post-ALU block
package postalu_cc_pkg;
   localparam logic [3:0] I_HALT = 4'h0;
   localparam logic [3:0] I_NOP = 4'h1;
   localparam logic [3:0] I_CXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ = 4'h6;
   localparam logic [3:0] I_JXX = 4'h7;
   localparam logic [3:0] I_CALL = 4'h8;
   localparam logic [3:0] I_RET = 4'h9;
   localparam logic [3:0] I_PUSHQ = 4'ha;
   localparam logic [3:0] I_POPQ = 4'hb;
   localparam logic [3:0] S_AOK = 4'h1;
   localparam logic [3:0] S_HLT = 4'h2;
   localparam logic [3:0] S_ADR = 4'h3;
   localparam logic [3:0] S_INS = 4'h4;
   localparam logic [3:0] RNONE = 4'hf;
   localparam logic [3:0] ALU_ADDQ = 4'h0;
   localparam logic [3:0] ALU_SUBQ = 4'h1;
   localparam logic [3:0] ALU_ANDQ = 4'h2;
   localparam logic [3:0] ALU_XORQ = 4'h3;
   localparam logic [2:0] CC_RESET_DEF = 3'b100;
   typedef enum logic [3:0] {
      C_ALL = 4'd0,
      C_LE = 4'd1,
      C_L = 4'd2,
      C_E = 4'd3,
      C_NE = 4'd4,
      C_GE = 4'd5,
      C_G = 4'd6
   } cond_e;
   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;
   // A downstream exception freezes architectural condition codes
   function automatic logic is_exc(input logic [3:0] s);
      return s == S_ADR || s == S_INS || s == S_HLT;
   endfunction
endpackage

// File: rtl/postalu_cc_cond_eval.sv
// postalu_cc_cond_eval: condition code + ifun -> taken flag for jXX/cmovXX
module postalu_cc_cond_eval
   import postalu_cc_pkg::*;
(
   input  cc_t        cc,
   input  logic [3:0] ifun,
   output logic       cnd
);
   logic lt;
   // signed less-than is SF^OF; undefined ifun codes are never taken
   always_comb begin
      lt = cc.sf ^ cc.of;
      cnd = ifun == C_ALL ? 1'b1 :
            ifun == C_LE  ? lt | cc.zf :
            ifun == C_L   ? lt :
            ifun == C_E   ? cc.zf :
            ifun == C_NE  ? ~cc.zf :
            ifun == C_GE  ? ~lt :
            ifun == C_G   ? ~lt & ~cc.zf : 1'b0;
   end
endmodule

// File: rtl/postalu_cc.sv
// postalu_cc: ALU flags, condition-code register, Cnd and E->M pipeline register
module postalu_cc
   import postalu_cc_pkg::*;
#(
   parameter int         DATA_W   = 64,
   parameter logic [2:0] CC_RESET = CC_RESET_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [3:0]        E_stat_i,
   input  logic [3:0]        E_icode_i,
   input  logic [3:0]        E_ifun_i,
   input  logic [DATA_W-1:0] E_valA_i,
   input  logic [3:0]        E_dstE_i,
   input  logic [3:0]        E_dstM_i,
   input  logic [DATA_W-1:0] aluA_i,
   input  logic [DATA_W-1:0] aluB_i,
   input  logic [3:0]        fun_i,
   input  logic [DATA_W-1:0] valE_i,
   input  logic [3:0]        m_stat_i,
   input  logic [3:0]        W_stat_i,
   input  logic              M_stall_i,
   input  logic              M_bubble_i,
   output logic [2:0]        cc_o,
   output logic              e_Cnd_o,
   output logic [3:0]        e_dstE_o,
   output logic [3:0]        M_stat_o,
   output logic [3:0]        M_icode_o,
   output logic              M_Cnd_o,
   output logic [DATA_W-1:0] M_valE_o,
   output logic [DATA_W-1:0] M_valA_o,
   output logic [3:0]        M_dstE_o,
   output logic [3:0]        M_dstM_o
);
   cc_t  cc_q, flags;
   logic set_cc, am, bm, vm, unused_low;
   assign unused_low = ^{aluA_i[DATA_W-2:0], aluB_i[DATA_W-2:0]};
   // flags of this cycle's result; overflow judged on sign bits only (SUBQ is b-a)
   always_comb begin
      am = aluA_i[DATA_W-1];
      bm = aluB_i[DATA_W-1];
      vm = valE_i[DATA_W-1];
      flags.zf = valE_i == '0;
      flags.sf = vm;
      flags.of = fun_i == ALU_ADDQ ? (am == bm) && (vm != am) :
                 fun_i == ALU_SUBQ ? (am != bm) && (vm != bm) : 1'b0;
      set_cc = E_icode_i == I_OPQ && !is_exc(m_stat_i) && !is_exc(W_stat_i);
   end
   // CC register, independent of E->M stall/bubble
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cc_q <= cc_t'(CC_RESET);
      else if (set_cc) cc_q <= flags;
   end
   assign cc_o = cc_q;
   postalu_cc_cond_eval u_cond_eval (
      .cc  (cc_q),
      .ifun(E_ifun_i),
      .cnd (e_Cnd_o)
   );
   assign e_dstE_o = (E_icode_i == I_CXX && !e_Cnd_o) ? RNONE : E_dstE_i;
   // E->M register: stall holds, bubble loads the idle NOP state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i || (M_bubble_i && !M_stall_i)) begin
         M_stat_o  <= S_AOK;
         M_icode_o <= I_NOP;
         M_Cnd_o   <= 1'b0;
         M_valE_o  <= '0;
         M_valA_o  <= '0;
         M_dstE_o  <= RNONE;
         M_dstM_o  <= RNONE;
      end else if (!M_stall_i) begin
         M_stat_o  <= E_stat_i;
         M_icode_o <= E_icode_i;
         M_Cnd_o   <= e_Cnd_o;
         M_valE_o  <= valE_i;
         M_valA_o  <= E_valA_i;
         M_dstE_o  <= e_dstE_o;
         M_dstM_o  <= E_dstM_i;
      end
   end
endmodule

// File: tb/tb_postalu_cc.sv
// tb_postalu_cc: randomized and directed checking of postalu_cc against a behavioural model
module tb_postalu_cc;
   import postalu_cc_pkg::*;
   localparam int W = 64;
   localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
   logic clk_i = 1'b0, rst_i = 1'b0;
   logic [3:0] E_stat_i, E_icode_i, E_ifun_i, E_dstE_i, E_dstM_i, fun_i, m_stat_i, W_stat_i;
   logic [W-1:0] E_valA_i, aluA_i, aluB_i, valE_i;
   logic M_stall_i, M_bubble_i;
   logic [2:0] cc_o;
   logic e_Cnd_o, M_Cnd_o;
   logic [3:0] e_dstE_o, M_stat_o, M_icode_o, M_dstE_o, M_dstM_o;
   logic [W-1:0] M_valE_o, M_valA_o;
   int checks = 0, errors = 0;
   bit run_cmp = 0;
   logic [2:0] mcc;
   logic [3:0] mstat, micode, mdste, mdstm;
   logic mcnd;
   logic [W-1:0] mvale, mvala;

   always #5 clk_i = ~clk_i;

   postalu_cc #(.DATA_W(W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .E_stat_i(E_stat_i), .E_icode_i(E_icode_i),
      .E_ifun_i(E_ifun_i), .E_valA_i(E_valA_i), .E_dstE_i(E_dstE_i), .E_dstM_i(E_dstM_i),
      .aluA_i(aluA_i), .aluB_i(aluB_i), .fun_i(fun_i), .valE_i(valE_i),
      .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .M_stall_i(M_stall_i), .M_bubble_i(M_bubble_i),
      .cc_o(cc_o), .e_Cnd_o(e_Cnd_o), .e_dstE_o(e_dstE_o), .M_stat_o(M_stat_o),
      .M_icode_o(M_icode_o), .M_Cnd_o(M_Cnd_o), .M_valE_o(M_valE_o), .M_valA_o(M_valA_o),
      .M_dstE_o(M_dstE_o), .M_dstM_o(M_dstM_o)
   );

   task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] alu(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      case (f)
         ALU_ADDQ: return a + b;
         ALU_SUBQ: return b - a;
         ALU_ANDQ: return a & b;
         default:  return a ^ b;
      endcase
   endfunction

   // {ZF,SF,OF}: overflow means the exact signed result does not fit in W bits
   function automatic logic [2:0] ref_flags(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
      logic signed [W:0] exact;
      logic ovf;
      exact = (f == ALU_ADDQ) ? $signed({a[W-1], a}) + $signed({b[W-1], b})
                              : $signed({b[W-1], b}) - $signed({a[W-1], a});
      ovf = (f == ALU_ADDQ || f == ALU_SUBQ) && (exact != $signed({r[W-1], r}));
      return {r == '0, $signed(r) < 0, ovf};
   endfunction

   function automatic logic ref_cnd(input logic [2:0] c, input logic [3:0] ifun);
      logic zf, lt;
      zf = c[2];
      lt = c[1] != c[0];
      case (ifun)
         4'd0: return 1'b1;
         4'd1: return lt || zf;
         4'd2: return lt;
         4'd3: return zf;
         4'd4: return !zf;
         4'd5: return !lt;
         4'd6: return !lt && !zf;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic stat_ok(input logic [3:0] s);
      return s != S_ADR && s != S_INS && s != S_HLT;
   endfunction

   function automatic logic [3:0] ref_dste(input logic [2:0] c);
      return (E_icode_i == I_CXX && !ref_cnd(c, E_ifun_i)) ? RNONE : E_dstE_i;
   endfunction

   // behavioural model of architectural state
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i || (M_bubble_i && !M_stall_i)) begin
         mstat <= S_AOK; micode <= I_NOP; mcnd <= 1'b0; mvale <= '0; mvala <= '0;
         mdste <= RNONE; mdstm <= RNONE;
      end else if (!M_stall_i) begin
         mstat <= E_stat_i; micode <= E_icode_i; mcnd <= ref_cnd(mcc, E_ifun_i);
         mvale <= valE_i; mvala <= E_valA_i; mdste <= ref_dste(mcc); mdstm <= E_dstM_i;
      end
      if (rst_i) mcc <= 3'b100;
      else if (E_icode_i == I_OPQ && stat_ok(m_stat_i) && stat_ok(W_stat_i))
         mcc <= ref_flags(fun_i, aluA_i, aluB_i, valE_i);
   end

   // per-cycle compare against the model
   always @(negedge clk_i) begin
      if (run_cmp) begin
         #2;
         chk("cc", cc_o, mcc);
         chk("e_Cnd", e_Cnd_o, ref_cnd(mcc, E_ifun_i));
         chk("e_dstE", e_dstE_o, ref_dste(mcc));
         chk("M_stat", M_stat_o, mstat);
         chk("M_icode", M_icode_o, micode);
         chk("M_Cnd", M_Cnd_o, mcnd);
         chk("M_valE", M_valE_o, mvale);
         chk("M_valA", M_valA_o, mvala);
         chk("M_dstE", M_dstE_o, mdste);
         chk("M_dstM", M_dstM_o, mdstm);
      end
   end

   task automatic idle();
      E_stat_i = S_AOK; E_icode_i = I_NOP; E_ifun_i = 4'd0; E_valA_i = '0;
      E_dstE_i = RNONE; E_dstM_i = RNONE; fun_i = ALU_ADDQ; aluA_i = '0; aluB_i = '0;
      valE_i = '0; m_stat_i = S_AOK; W_stat_i = S_AOK; M_stall_i = 1'b0; M_bubble_i = 1'b0;
   endtask

   task automatic op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      idle();
      E_icode_i = I_OPQ; fun_i = f; aluA_i = a; aluB_i = b; valE_i = alu(f, a, b);
      E_dstE_i = 4'd3;
   endtask

   task automatic cmov(input logic [3:0] ifun);
      idle();
      E_icode_i = I_CXX; E_ifun_i = ifun; E_dstE_i = 4'd2; E_valA_i = 64'h77;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 1;
         2: return MAXP;
         3: return MINN;
         4: return '1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      idle();
      #1 rst_i = 1'b1;
      @(negedge clk_i) rst_i = 1'b0;
      run_cmp = 1;
      @(negedge clk_i) op(ALU_ADDQ, 1, 1);
      @(negedge clk_i) op(ALU_ADDQ, 1, 1);
      #3 chk("cc_before_reset", cc_o, 3'b000);
      rst_i = 1'b1;
      #1 chk("rst_cc", cc_o, 3'b100);
      chk("rst_icode", M_icode_o, I_NOP);
      chk("rst_stat", M_stat_o, S_AOK);
      chk("rst_dstE", M_dstE_o, RNONE);
      chk("rst_dstM", M_dstM_o, RNONE);
      @(negedge clk_i) rst_i = 1'b0;
      op(ALU_ADDQ, 1, 1);
      @(negedge clk_i) op(ALU_SUBQ, 1, 1);
      #3 chk("cc_add_1_1", cc_o, 3'b000);
      @(negedge clk_i) op(ALU_ADDQ, MAXP, MAXP);
      #3 chk("cc_sub_zero", cc_o, 3'b100);
      chk("valE_addmax", valE_i, 64'hFFFF_FFFF_FFFF_FFFE);
      @(negedge clk_i) op(ALU_ADDQ, 1, 1);
      #3 chk("cc_add_ovf", cc_o, 3'b011);
      @(negedge clk_i) cmov(4'd1);
      #3 chk("cmovle_nt_cnd", e_Cnd_o, 1'b0);
      chk("cmovle_nt_dstE", e_dstE_o, RNONE);
      @(negedge clk_i) op(ALU_ADDQ, '0, '1);
      #3 chk("cmovle_nt_M_dstE", M_dstE_o, RNONE);
      @(negedge clk_i) cmov(4'd1);
      #3 chk("cc_sf_only", cc_o, 3'b010);
      chk("cmovle_t_cnd", e_Cnd_o, 1'b1);
      @(negedge clk_i) op(ALU_ADDQ, '0, '0);
      m_stat_i = S_ADR; E_valA_i = 64'h55;
      #3 chk("cmovle_t_M_dstE", M_dstE_o, 4'd2);
      @(negedge clk_i) idle();
      M_stall_i = 1'b1; M_bubble_i = 1'b1; E_valA_i = 64'h99; E_icode_i = I_RET;
      #3 chk("cc_sadr_hold", cc_o, 3'b010);
      chk("M_icode_sadr", M_icode_o, I_OPQ);
      @(negedge clk_i) op(ALU_ADDQ, 1, 1);
      M_stall_i = 1'b1; M_bubble_i = 1'b1;
      #3 chk("stall1_valA", M_valA_o, 64'h55);
      chk("stall1_icode", M_icode_o, I_OPQ);
      @(negedge clk_i) idle();
      M_bubble_i = 1'b1; E_icode_i = I_CALL;
      #3 chk("stall2_valA", M_valA_o, 64'h55);
      chk("stall2_icode", M_icode_o, I_OPQ);
      chk("cc_during_stall", cc_o, 3'b000);
      @(negedge clk_i) op(ALU_XORQ, 64'h1234, 64'h1234);
      #3 chk("bubble_icode", M_icode_o, I_NOP);
      chk("bubble_stat", M_stat_o, S_AOK);
      @(negedge clk_i) idle();
      E_icode_i = I_JXX; E_ifun_i = 4'd4;
      #3 chk("jne_after_xor", e_Cnd_o, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_i);
         case ($urandom_range(0, 5))
            0, 1, 2: E_icode_i = I_OPQ;
            3: E_icode_i = I_CXX;
            4: E_icode_i = I_JXX;
            default: E_icode_i = 4'($urandom_range(0, 11));
         endcase
         E_stat_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 4)) : S_AOK;
         E_ifun_i = 4'($urandom_range(0, 8));
         E_valA_i = {$urandom, $urandom};
         E_dstE_i = 4'($urandom_range(0, 15));
         E_dstM_i = 4'($urandom_range(0, 15));
         fun_i = 4'($urandom_range(0, 3));
         aluA_i = pick();
         aluB_i = pick();
         valE_i = alu(fun_i, aluA_i, aluB_i);
         m_stat_i = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 4)) : S_AOK;
         W_stat_i = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 4)) : S_AOK;
         M_stall_i = $urandom_range(0, 7) == 0;
         M_bubble_i = $urandom_range(0, 7) == 0;
      end
      @(negedge clk_i);
      #3 $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
